// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 640x480@60 raster constants, derived totals and the helper
//             functions used to size the per-axis counters.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 0 selects active-low sync, the 640x480@60 standard
  localparam bit VGA_SYNC_ACTIVE_HIGH = 1'b0;

  // Number of counter states in one axis period
  function automatic int axis_total(int visible, int front, int sync, int back);
    return visible + front + sync + back;
  endfunction

  // Counter width for a given period; never narrower than one bit
  function automatic int axis_width(int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_controller_if
//  Purpose  : Raster timing bundle from the timing generator (master) to the
//             colour sources (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_controller_if;

  logic [15:0] o_horz_coord;
  logic [15:0] o_vert_coord;
  logic        o_in_active_area;
  logic        o_horz_sync;
  logic        o_vert_sync;
  logic        o_line_start;
  logic        o_frame_start;
  logic [7:0]  o_frame_count;

  modport master (
    output o_horz_coord, o_vert_coord, o_in_active_area,
           o_horz_sync, o_vert_sync, o_line_start, o_frame_start, o_frame_count
  );

  modport slave (
    input  o_horz_coord, o_vert_coord, o_in_active_area,
           o_horz_sync, o_vert_sync, o_line_start, o_frame_start, o_frame_count
  );

endinterface : vga_timing_controller_if
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One raster axis: wrapping position counter plus decoded
//             visible-region and sync-window flags and a wrap strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int CNT_W   = axis_width(axis_total(VISIBLE, FRONT, SYNC, BACK))
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_advance,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_active,
  output logic                  o_sync_window,
  output logic                  o_wrap
);

  localparam int               c_total      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] c_last       = CNT_W'(c_total - 1);
  localparam logic [CNT_W-1:0] c_visible    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] c_sync_first = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] c_sync_last  = CNT_W'(VISIBLE + FRONT + SYNC - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == c_last);

  // Position counter: step on advance, fold back to zero after the last state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_advance) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

  // Region decode straight from the registered position
  always_comb begin
    o_count       = r_count;
    o_active      = (r_count < c_visible);
    o_sync_window = (r_count >= c_sync_first) && (r_count <= c_sync_last);
    o_wrap        = i_advance && w_at_last;
  end

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_controller
//  Purpose  : VGA raster timing from the pixel clock: sync pulses, active
//             flag, pixel coordinates, line/frame strobes and frame counter.
//             All outputs decode combinationally from the counter registers.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE        = VGA_H_VISIBLE,
  parameter int H_FRONT          = VGA_H_FRONT,
  parameter int H_SYNC           = VGA_H_SYNC,
  parameter int H_BACK           = VGA_H_BACK,
  parameter int V_VISIBLE        = VGA_V_VISIBLE,
  parameter int V_FRONT          = VGA_V_FRONT,
  parameter int V_SYNC           = VGA_V_SYNC,
  parameter int V_BACK           = VGA_V_BACK,
  parameter bit SYNC_ACTIVE_HIGH = VGA_SYNC_ACTIVE_HIGH
) (
  input  wire logic               i_pix_clk,
  input  wire logic               i_reset,
  vga_timing_controller_if.master o_vga
);

  localparam int c_h_w = axis_width(axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK));
  localparam int c_v_w = axis_width(axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK));

  logic [c_h_w-1:0] w_h_count;
  logic [c_v_w-1:0] w_v_count;
  logic             w_h_active, w_h_sync, w_h_wrap;
  logic             w_v_active, w_v_sync, w_v_wrap;
  logic             w_active, w_hsync_on, w_vsync_on, w_line_start;
  logic [7:0]       r_frame_count;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .CNT_W   (c_h_w)
  ) u_horz (
    .clk           (i_pix_clk),
    .rst           (i_reset),
    .i_advance     (1'b1),
    .o_count       (w_h_count),
    .o_active      (w_h_active),
    .o_sync_window (w_h_sync),
    .o_wrap        (w_h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .CNT_W   (c_v_w)
  ) u_vert (
    .clk           (i_pix_clk),
    .rst           (i_reset),
    .i_advance     (w_h_wrap),
    .o_count       (w_v_count),
    .o_active      (w_v_active),
    .o_sync_window (w_v_sync),
    .o_wrap        (w_v_wrap)
  );

  // Completed-frame counter; bumps on the same edge the raster returns to (0,0)
  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      r_frame_count <= 8'd0;
    end else if (w_v_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  // Output decode; reset overrides whatever the counters hold
  always_comb begin
    w_active     = !i_reset && w_h_active && w_v_active;
    w_hsync_on   = !i_reset && w_h_sync;
    w_vsync_on   = !i_reset && w_v_sync;
    w_line_start = !i_reset && (w_h_count == '0);

    o_vga.o_in_active_area = w_active;
    o_vga.o_horz_coord     = w_active ? 16'(w_h_count) : 16'd0;
    o_vga.o_vert_coord     = w_active ? 16'(w_v_count) : 16'd0;
    o_vga.o_horz_sync      = SYNC_ACTIVE_HIGH ? w_hsync_on : !w_hsync_on;
    o_vga.o_vert_sync      = SYNC_ACTIVE_HIGH ? w_vsync_on : !w_vsync_on;
    o_vga.o_line_start     = w_line_start;
    o_vga.o_frame_start    = w_line_start && (w_v_count == '0);
    o_vga.o_frame_count    = i_reset ? 8'd0 : r_frame_count;
  end

endmodule : vga_timing_controller
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_controller
//  Purpose  : Self-checking bench: default 640x480 instance and a tiny
//             4/1/1/1 x 3/1/1/1 active-high instance, checked against an
//             arithmetic raster model plus hand-written vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  typedef struct {
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    bit pol;
  } cfg_t;

  typedef struct {
    int   t;
    out_t exp;
  } vec_t;

  localparam int NV = 12;
  localparam int SMALL_FRAME = 42;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   t_d = 0;
  int   t_s = 0;
  int   checks = 0;
  int   errors = 0;
  cfg_t cfg_d, cfg_s;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  vga_timing_controller_if if_d ();
  vga_timing_controller_if if_s ();

  vga_timing_controller u_dut_d (
    .i_pix_clk (clk),
    .i_reset   (rst_d),
    .o_vga     (if_d)
  );

  vga_timing_controller #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_ACTIVE_HIGH (1'b1)
  ) u_dut_s (
    .i_pix_clk (clk),
    .i_reset   (rst_s),
    .o_vga     (if_s)
  );

  // Clocks elapsed since each instance left reset
  always @(posedge clk) begin
    t_d <= rst_d ? 0 : t_d + 1;
    t_s <= rst_s ? 0 : t_s + 1;
  end

  function automatic out_t mk(int hc, int vc, bit act, bit hs, bit vs, bit ls, bit fs, int fc);
    out_t o;
    o.hc = 16'(hc); o.vc = 16'(vc); o.act = act; o.hs = hs; o.vs = vs;
    o.ls = ls; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  // Raster position is pure arithmetic on elapsed clocks since reset
  function automatic out_t model(cfg_t c, bit rst, int t);
    int ht, vt, h, line, v, f;
    bit act, hon, von;
    if (rst) return mk(0, 0, 0, !c.pol, !c.pol, 0, 0, 0);
    ht   = c.hv + c.hf + c.hsw + c.hb;
    vt   = c.vv + c.vf + c.vsw + c.vb;
    h    = t % ht;
    line = t / ht;
    v    = line % vt;
    f    = (line / vt) % 256;
    act  = (h < c.hv) && (v < c.vv);
    hon  = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hsw);
    von  = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vsw);
    return mk(act ? h : 0, act ? v : 0, act, c.pol ? hon : !hon, c.pol ? von : !von,
              h == 0, (h == 0) && (v == 0), f);
  endfunction

  function automatic out_t sample_d();
    return {if_d.o_horz_coord, if_d.o_vert_coord, if_d.o_in_active_area, if_d.o_horz_sync,
            if_d.o_vert_sync, if_d.o_line_start, if_d.o_frame_start, if_d.o_frame_count};
  endfunction

  function automatic out_t sample_s();
    return {if_s.o_horz_coord, if_s.o_vert_coord, if_s.o_in_active_area, if_s.o_horz_sync,
            if_s.o_vert_sync, if_s.o_line_start, if_s.o_frame_start, if_s.o_frame_count};
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got hc=%0d vc=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected hc=%0d vc=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, got.hc, got.vc, got.act, got.hs, got.vs, got.ls, got.fs, got.fc,
               exp.hc, exp.vc, exp.act, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic check_models();
    check("model_default", sample_d(), model(cfg_d, rst_d, t_d));
    check("model_small", sample_s(), model(cfg_s, rst_s, t_s));
  endtask

  task automatic tick();
    @(negedge clk);
    check_models();
  endtask

  task automatic wait_small(int n);
    for (int k = 0; k < 2000 && t_s < n; k++) tick();
    checks++;
    if (t_s != n) begin
      errors++;
      $display("FAIL wait_small got t=%0d expected t=%0d", t_s, n);
    end
  endtask

  initial begin
    cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg_s = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1};

    // Line-0/1/2 checkpoints for the default raster, hand-derived
    tbl[0]  = '{0,    mk(0,   0, 1, 1, 1, 1, 1, 0)};
    tbl[1]  = '{1,    mk(1,   0, 1, 1, 1, 0, 0, 0)};
    tbl[2]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{640,  mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[4]  = '{655,  mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[5]  = '{656,  mk(0,   0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{751,  mk(0,   0, 0, 0, 1, 0, 0, 0)};
    tbl[7]  = '{752,  mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[8]  = '{799,  mk(0,   0, 0, 1, 1, 0, 0, 0)};
    tbl[9]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0, 0)};
    tbl[10] = '{1500, mk(0,   0, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{1605, mk(5,   2, 1, 1, 1, 0, 0, 0)};

    // Reset held for 5 clocks: everything at reset value
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_default", sample_d(), mk(0, 0, 0, 1, 1, 0, 0, 0));
      check("reset_small", sample_s(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    end

    // Release: first clock shows (0,0) active with both strobes
    rst_d = 1'b0;
    rst_s = 1'b0;
    #1;
    check_models();
    check("first_after_reset", sample_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));

    begin : line_timing
      int idx;
      idx = 0;
      while (t_d < 2400) begin
        if (idx < NV && t_d == tbl[idx].t) begin
          check($sformatf("line_vec_t%0d", tbl[idx].t), sample_d(), tbl[idx].exp);
          idx++;
        end
        tick();
      end
      checks++;
      if (idx != NV) begin
        errors++;
        $display("FAIL line_vec_coverage got %0d expected %0d", idx, NV);
      end
    end

    // Small config: restart cleanly, then walk through the frame corners
    tick();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    #1;
    check("small_restart", sample_s(), mk(0, 0, 1, 0, 0, 1, 1, 0));
    wait_small(5);
    check("small_hsync", sample_s(), mk(0, 0, 0, 1, 0, 0, 0, 0));
    wait_small(28);
    check("small_vsync", sample_s(), mk(0, 0, 0, 0, 1, 1, 0, 0));
    wait_small(SMALL_FRAME);
    check("small_frame1", sample_s(), mk(0, 0, 1, 0, 0, 1, 1, 1));

    // Mid-frame reset at line 3, clock 2 of frame 1 for one clock
    wait_small(SMALL_FRAME + 23);
    rst_s = 1'b1;
    #1;
    check("midreset_hold", sample_s(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_s = 1'b0;
    #1;
    check("midreset_restart", sample_s(), mk(0, 0, 1, 0, 0, 1, 1, 0));

    // Random reset pulses against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 63) == 0) begin
        rst_s = 1'b1;
        #1;
        check_models();
      end else if (rst_s && ($urandom_range(0, 1) == 1)) begin
        rst_s = 1'b0;
        #1;
        check_models();
      end
    end

    // 256 uninterrupted small frames: counter wraps back to 0
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    #1;
    check_models();
    for (int k = 0; k < 256 * SMALL_FRAME; k++) begin
      tick();
      if (t_s == 255 * SMALL_FRAME)
        check("frame_count_255", sample_s(), mk(0, 0, 1, 0, 0, 1, 1, 255));
    end
    check("frame_count_wrap", sample_s(), mk(0, 0, 1, 0, 0, 1, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing_controller
`default_nettype wire

// File: doc/vga_timing_controller.md
# vga_timing_controller

Generates VGA raster timing from a single pixel clock: horizontal/vertical counters, sync pulses, the active-area flag and the pixel coordinates that drive the pixel-colour generator (test pattern or later framebuffer reader). It sits between the pixel-clock domain root and every colour source, and sequences them by supplying coordinates plus line/frame-start strobes and a frame counter for animation.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, sync polarity; 0 = active-low (640x480@60)
- i_pix_clk  in  1  pixel clock; sole clock
- i_reset  in  1  synchronous, active-high reset
- o_horz_coord  out  16  pixel x within active area, else 0
- o_vert_coord  out  16  line y within active area, else 0
- o_in_active_area  out  1  high when h < H_VISIBLE and v < V_VISIBLE
- o_horz_sync  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- o_vert_sync  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- o_line_start  out  1  one-cycle pulse at h == 0
- o_frame_start  out  1  one-cycle pulse at h == 0, v == 0
- o_frame_count  out  8  completed-frame counter, wraps 255 -> 0

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- h counter: 0..H_TOTAL-1, +1 every clock; at H_TOTAL-1 wraps to 0.
- v counter: advances only on h wrap; at V_TOTAL-1 with h wrap, wraps to 0 and o_frame_count increments (mod 256).
- Horizontal sync asserted for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 default).
- Vertical sync asserted for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 default); changes on the h-wrap clock edge together with v.
- Coordinates: zero-extended h/v when o_in_active_area, else both 0 (both forced 0 whenever outside the active area, including hblank on visible lines).
- Counters sized to clog2 of totals internally; outputs zero-extended to 16 bits.
- While i_reset high: h = v = 0, o_frame_count = 0; all outputs forced to reset values regardless of counter state.
- Reset values: coords 0, o_in_active_area 0, syncs deasserted (1 if active-low, 0 if active-high), o_line_start 0, o_frame_start 0, o_frame_count 0.
- Reset mid-frame: next cycle after deassertion restarts at h = v = 0; no partial sync pulse retained; o_frame_count does not increment for the aborted frame.

## Timing
- Counters registered; all outputs decoded combinationally from counter registers (zero latency relative to h/v), gated by i_reset.
- First clock after reset release: h = 0, v = 0, o_in_active_area = 1, o_line_start = o_frame_start = 1, coords (0,0).
- Frame period exactly H_TOTAL * V_TOTAL clocks (420000 default); o_frame_start period identical.
- o_frame_count increments on the same edge where v wraps to 0, so it reads the new value during the o_frame_start cycle.
- Colour sources must be combinational from coordinates to stay aligned; a registered source must delay syncs itself.

## Structure
- Package vga_timing_pkg: 640x480@60 parameter constants, derived H_TOTAL/V_TOTAL, sync polarity constant.
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical): parameters visible/front/sync/back; inputs clock, reset, advance enable; outputs count, active, sync-window, wrap. Vertical instance enabled by horizontal wrap.

## Test plan
- Reset: hold i_reset 5 clocks -> coords 0, active 0, syncs 1 (active-low), strobes 0, frame_count 0; first post-reset clock active 1, frame_start 1.
- Line timing (defaults): horz_sync low exactly on clocks 656..751 of line 0; active 0 and coords 0 from clock 640; line_start again at clock 800 with vert_coord 1.
- Frame wrap: run 420000 clocks -> vert_sync low only on lines 490..491; frame_start at clock 420000; frame_count = 1; 256 short frames -> wraps to 0.
- Reset mid-frame: assert at line 300 clock 100 for 1 clock -> next clock h = v = 0, frame_start 1, frame_count 0 / unchanged-minus-none.
- Small config (4/1/1/1 x 3/1/1/1, SYNC_ACTIVE_HIGH=1): H_TOTAL 7, V_TOTAL 6; hsync high only at h = 5; vsync high only at v = 4; frame period 42 clocks.
